// File: rtl/pim_pkg.sv
// Shared definitions for the PIM slice sequencer: FSM state encoding,
// crossbar geometry limits and the slice-count helpers used to size ports.
package pim_pkg;

   // Largest crossbar geometry this codebase targets
   localparam int MAX_CXB_ROW = 128;
   localparam int MAX_CXB_COL = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } pim_state_t;

   // Number of crossbar slices the input vector is split into
   function automatic int calc_num_slices(input int input_size, input int xb_rows);
      return input_size / xb_rows;
   endfunction

   // Slice index width; never below one bit so single-slice builds still have a port
   function automatic int calc_slice_bits(input int input_size, input int xb_rows);
      int n;
      n = input_size / xb_rows;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pim_xbar_tile.sv
// Crossbar weight store shared by all slices. A read ANDs the presented
// input slice with one stored weight column and returns the popcount one
// cycle later, together with a valid and a last-slice marker.
module pim_xbar_tile
   import pim_pkg::*;
#(
   parameter int XB_ROWS     = MAX_CXB_ROW,
   parameter int ADDRS_WIDTH = MAX_CXB_COL,
   parameter int OUT_WIDTH   = 8,
   parameter int SLICE_BITS  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [SLICE_BITS-1:0]  wr_slice,
   input  logic [ADDRS_WIDTH-1:0] wr_addr,
   input  logic [XB_ROWS-1:0]     wr_data,
   input  logic                   rd_en,
   input  logic                   rd_last,
   input  logic [SLICE_BITS-1:0]  rd_slice,
   input  logic [ADDRS_WIDTH-1:0] rd_addr,
   input  logic [XB_ROWS-1:0]     rd_data,
   output logic                   vld_p1,
   output logic                   last_p1,
   output logic [OUT_WIDTH-1:0]   pop_p1
);

   // Array is sized by the full index range so every index value is in bounds
   localparam int SLICE_ENTRIES = 1 << SLICE_BITS;
   localparam int COL_ENTRIES   = 1 << ADDRS_WIDTH;

   logic [XB_ROWS-1:0] weight [SLICE_ENTRIES][COL_ENTRIES];
   logic [XB_ROWS-1:0] match_p0;

   // Count of set bits, wrapping naturally at OUT_WIDTH
   function automatic logic [OUT_WIDTH-1:0] popcount(input logic [XB_ROWS-1:0] bits);
      logic [OUT_WIDTH-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < XB_ROWS; i++) begin
         cnt = cnt + OUT_WIDTH'(bits[i]);
      end
      return cnt;
   endfunction

   assign match_p0 = rd_data & weight[rd_slice][rd_addr];

   // Weight storage write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         weight[wr_slice][wr_addr] <= wr_data;
      end
   end

   // --- stage p0 -> p1: registered popcount read ---
   // Read valid and last marker are control and follow reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1  <= rd_en;
         last_p1 <= rd_en && rd_last;
      end
   end

   // Popcount data register, only loaded on a read
   always_ff @(posedge clk) begin
      if (rd_en) begin
         pop_p1 <= popcount(match_p0);
      end
   end

endmodule

// File: rtl/pim_slice_sequencer.sv
// PIM slice sequencer: accepts a MAC request, walks the input vector one
// crossbar slice per cycle through pim_xbar_tile, accumulates the tile
// popcounts and holds the result until it is consumed.
// Build option: define PIM_SAT_EN to saturate the accumulator instead of
// wrapping; out_ovf flags the carry-out in both builds.
module pim_slice_sequencer
   import pim_pkg::*;
#(
   parameter int INPUT_SIZE  = 512,
   parameter int XB_ROWS     = MAX_CXB_ROW,
   parameter int ADDRS_WIDTH = MAX_CXB_COL,
   parameter int OUT_WIDTH   = 8,
   parameter int ACC_WIDTH   = 8,
   localparam int NUM_SLICES = calc_num_slices(INPUT_SIZE, XB_ROWS),
   localparam int SLICE_BITS = calc_slice_bits(INPUT_SIZE, XB_ROWS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_SIZE-1:0]  in_data,
   input  logic [ADDRS_WIDTH-1:0] in_addr,
   input  logic                   wr_en,
   input  logic [SLICE_BITS-1:0]  wr_slice,
   input  logic [ADDRS_WIDTH-1:0] wr_addr,
   input  logic [XB_ROWS-1:0]     wr_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_WIDTH-1:0]   out_data,
   output logic                   out_ovf
);

   localparam logic [SLICE_BITS-1:0] LAST_SLICE = SLICE_BITS'(NUM_SLICES - 1);

   pim_state_t             state;
   pim_state_t             state_nxt;
   logic                   accept;
   logic                   issue;
   logic                   last_issue;
   logic [INPUT_SIZE-1:0]  data_q;
   logic [ADDRS_WIDTH-1:0] addr_q;
   logic [SLICE_BITS-1:0]  slice_cnt;
   logic [XB_ROWS-1:0]     slice_p0;
   logic                   tile_vld_p1;
   logic                   tile_last_p1;
   logic [OUT_WIDTH-1:0]   tile_pop_p1;
   logic [ACC_WIDTH:0]     acc_sum_p1;
   logic [ACC_WIDTH-1:0]   acc_p2;
   logic                   ovf_p2;

   // Add one tile result; bit ACC_WIDTH of the return value is the carry-out
   function automatic logic [ACC_WIDTH:0] accumulate(input logic [ACC_WIDTH-1:0] acc,
                                                     input logic [OUT_WIDTH-1:0] add);
      logic [ACC_WIDTH:0] sum;
      sum = {1'b0, acc} + (ACC_WIDTH+1)'(add);
`ifdef PIM_SAT_EN
      if (sum[ACC_WIDTH]) begin
         sum[ACC_WIDTH-1:0] = '1;
      end
`endif
      return sum;
   endfunction

   // A pending weight write always wins over a request in the same cycle
   assign in_ready   = (state == IDLE) && !wr_en;
   assign accept     = in_valid && in_ready;
   assign out_valid  = (state == HOLD);
   assign last_issue = (slice_cnt == LAST_SLICE);
   assign slice_p0   = data_q[int'(slice_cnt)*XB_ROWS +: XB_ROWS];
   assign acc_sum_p1 = accumulate(acc_p2, tile_pop_p1);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and slice-issue decode
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            if (last_issue) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (tile_vld_p1 && tile_last_p1) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request capture; held for the whole operation
   always_ff @(posedge clk) begin
      if (accept) begin
         data_q <= in_data;
         addr_q <= in_addr;
      end
   end

   // Slice counter, parks on the last slice until the next accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slice_cnt <= '0;
      end else if (accept) begin
         slice_cnt <= '0;
      end else if (issue && !last_issue) begin
         slice_cnt <= slice_cnt + 1'b1;
      end
   end

   // --- stage p0 -> p1: crossbar read ---
   pim_xbar_tile #(
      .XB_ROWS     (XB_ROWS),
      .ADDRS_WIDTH (ADDRS_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .SLICE_BITS  (SLICE_BITS)
   ) u_tile (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en && (state == IDLE)),
      .wr_slice (wr_slice),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (issue),
      .rd_last  (last_issue),
      .rd_slice (slice_cnt),
      .rd_addr  (addr_q),
      .rd_data  (slice_p0),
      .vld_p1   (tile_vld_p1),
      .last_p1  (tile_last_p1),
      .pop_p1   (tile_pop_p1)
   );

   // --- stage p1 -> p2: accumulate every valid tile result ---
   // Overflow is sticky for the operation and cleared on accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_p2 <= '0;
         ovf_p2 <= 1'b0;
      end else if (accept) begin
         acc_p2 <= '0;
         ovf_p2 <= 1'b0;
      end else if (tile_vld_p1) begin
         acc_p2 <= acc_sum_p1[ACC_WIDTH-1:0];
         ovf_p2 <= ovf_p2 | acc_sum_p1[ACC_WIDTH];
      end
   end

   // Result register: the final slice is folded in directly on its way out
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data <= '0;
         out_ovf  <= 1'b0;
      end else if ((state == DRAIN) && tile_vld_p1 && tile_last_p1) begin
         out_data <= acc_sum_p1[ACC_WIDTH-1:0];
         out_ovf  <= ovf_p2 | acc_sum_p1[ACC_WIDTH];
      end
   end

endmodule
